// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
`ifdef PIPE_PERF_EN
    ,
    parameter int                CNT_W     = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_fire_s;
    logic              out_fire_s;

    // Ready depends only on the state register and reset, never on out_ready.
    assign in_ready   = (state_q != ST_FULL) & ~RST;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Occupancy decode from the state register.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    // Next-state and storage update; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else if (in_fire_s) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counters, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush && (state_q != ST_EMPTY) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with a queue-based reference model checked every cycle.
module tb_pipe_stage_buf;

    localparam logic [31:0] FV  = 32'h0000_0013;
    localparam int          SAT = 7;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
`ifdef PIPE_PERF_EN
    logic [2:0]  stall_cnt;
    logic [2:0]  flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq[$];
    bit          m_clean = 1'b1;
    int          m_stall = 0;
    int          m_flush = 0;
    bit          chk_en  = 1'b0;
    int          n;
    bit          m_inf;
    bit          m_outf;

`ifdef PIPE_PERF_EN
    pipe_stage_buf #(.DATA_W(32), .FLUSH_VAL(FV), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    pipe_stage_buf #(.DATA_W(32), .FLUSH_VAL(FV)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of at most two payloads.
    always @(posedge CLK) begin
        n = mq.size();
        if (RST) begin
            mq.delete();
            m_clean = 1'b1;
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_inf  = in_valid && (n < 2);
            m_outf = (n > 0) && out_ready;
            if (n > 0 && !out_ready && !flush && m_stall < SAT) m_stall++;
            if (flush) begin
                if (n > 0 && m_flush < SAT) m_flush++;
                mq.delete();
                m_clean = 1'b1;
            end else begin
                if (m_outf) void'(mq.pop_front());
                if (m_inf) begin
                    mq.push_back(in_data);
                    m_clean = 1'b0;
                end
            end
        end
    end

    // Compare process, sampling away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            chk("m_occupancy", {30'd0, occupancy}, mq.size());
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!RST && mq.size() < 2)});
            if (mq.size() > 0) chk("m_out_data", out_data, mq[0]);
            else if (m_clean) chk("m_out_data_nop", out_data, FV);
`ifdef PIPE_PERF_EN
            chk("m_stall_cnt", {29'd0, stall_cnt}, m_stall);
            chk("m_flush_cnt", {29'd0, flush_cnt}, m_flush);
`endif
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        RST = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        chk_en = 1'b1;
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_out_data", out_data, FV);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t1_in_ready_rel", {31'd0, in_ready}, 32'd1);
        chk("t1_occ_rel", {30'd0, occupancy}, 32'd0);

        // Back-to-back streaming.
        drive(1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
        tick();
        chk("t2_d1", out_data, 32'h1);
        drive(1'b0, 1'b0, 1'b1, 32'h2, 1'b1);
        tick();
        chk("t2_d2", out_data, 32'h2);
        chk("t2_occ", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
        tick();
        chk("t2_d3", out_data, 32'h3);
        chk("t2_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t2_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure into the skid register.
        drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
        tick();
        chk("t3_occ_full", {30'd0, occupancy}, 32'd2);
        chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
        chk("t3_head", out_data, 32'hA);
        drive(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        tick();
        chk("t3_second", out_data, 32'hB);
        chk("t3_occ_one", {30'd0, occupancy}, 32'd1);
        tick();
        chk("t3_third", out_data, 32'hC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t3_empty", {30'd0, occupancy}, 32'd0);

        // Flush from FULL discards a simultaneous push.
        drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
        tick();
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_occ", {30'd0, occupancy}, 32'd0);
        chk("t4_data", out_data, FV);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("t4_no_c", {31'd0, out_valid}, 32'd0);
`ifdef PIPE_PERF_EN
        chk("t4_flush_cnt", {29'd0, flush_cnt}, 32'd1);
`endif

        // Flush in ONE while downstream consumes the head.
        drive(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h66, 1'b1);
        tick();
        chk("t4b_empty", {31'd0, out_valid}, 32'd0);

        // Reset together with flush while FULL.
        drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_out_data", out_data, FV);
        chk("t5_occ", {30'd0, occupancy}, 32'd0);
`ifdef PIPE_PERF_EN
        chk("t5_flush_cnt", {29'd0, flush_cnt}, 32'd0);
`endif

        // Long stall for counter saturation.
        drive(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_PERF_EN
        chk("t6_stall5", {29'd0, stall_cnt}, 32'd5);
`endif
        for (int i = 0; i < 10; i++) tick();
`ifdef PIPE_PERF_EN
        chk("t6_stall_sat", {29'd0, stall_cnt}, 32'd7);
`endif
        chk("t6_hold", out_data, 32'h5);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
